gcn_input_mem_server: RTL and testbench
=======================================

// Module: gcn_input_mem_server
// PURPOSE
//  Synthesizable memory responder for the GCN core's operand-fetch interface. It is the
//  responder end of the GCN fetch interface: it answers enable_read/read_address with one
//  full weight or feature row, and coo_address with one COO column.
//  A streaming load port fills the weight, feature and COO stores before the GCN runs.
//  Sits between the host/DMA loader and the GCN DUT: data_out feeds data_in, coo_out feeds coo_in.
// PARAMETERS
//  FEATURE_ROWS     6    feature-matrix rows (graph nodes)
//  FEATURE_COLS     96   feature-matrix cols = elements per returned row
//  WEIGHT_COLS      3    weight rows stored (one per output class)
//  ELEM_WIDTH       5    bits per feature/weight element
//  ADDRESS_WIDTH    13   read_address width
//  FEATURE_BASE     512  first feature-row address (10'b10_0000_0000)
//  COO_NUM_OF_COLS  6    COO entries per row
//  COO_NUM_OF_ROWS  2    COO rows (row 0 = source, row 1 = destination)
//  COO_BW           3    bits per COO entry ($clog2(COO_NUM_OF_COLS))
// PORTS
//  clk           in   1                        rising-edge clock
//  reset         in   1                        asynchronous, active-low reset
//  load_start    in   1                        pulse: begin (re)load sequence
//  load_valid    in   1                        load_data valid
//  load_data     in   ELEM_WIDTH               one element per beat (COO beats use [COO_BW-1:0])
//  load_ready    out  1                        high while in LOAD
//  mem_ready     out  1                        stores fully loaded, reads served
//  enable_read   in   1                        row-read request
//  read_address  in   ADDRESS_WIDTH            row address
//  data_out      out  FEATURE_COLS*ELEM_WIDTH  row; element 0 in MSBs [479:475]
//  data_valid    out  1                        one-cycle strobe per accepted read
//  coo_address   in   COO_BW                   COO column index
//  coo_out       out  COO_NUM_OF_ROWS*COO_BW   {row0[col], row1[col]}, row0 in MSBs
//  addr_err      out  1                        sticky out-of-range read flag
//  read_count    out  16                       accepted-read counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE; load counter 0. Outputs cleared: load_ready,
//    mem_ready, data_out, data_valid, coo_out, addr_err and read_count all 0.
//    Store contents are not reset; mem_ready==0 guards them.
//  - FSM IDLE -> LOAD on load_start. LOAD -> SERVE when the final beat is accepted.
//    SERVE -> LOAD on load_start. There is no other exit from SERVE.
//  - LOAD: load_ready=1; a beat is accepted when load_valid&&load_ready at a rising edge.
//    Beat order: weights, row-major (3x96 = 288 beats), then features (6x96 = 576 beats),
//    then COO row 0 then row 1 (12 beats). Total 876 beats; counter runs 0..875.
//  - load_start while in LOAD restarts the counter at 0. If load_valid is high in the same
//    cycle, restart wins and that beat is dropped. Already-written entries stay until overwritten.
//  - Reload from SERVE drops mem_ready on the next edge. Any data_out already registered is held.
//  - Reads (SERVE only). When enable_read is sampled high at edge N, data_out is registered
//    at edge N, and data_valid=1 for exactly the cycle after edge N (1-cycle latency).
//    Back-to-back reads give one row per cycle.
//  - Address decode:
//      addr < WEIGHT_COLS                                -> weight row[addr]
//      FEATURE_BASE <= addr < FEATURE_BASE+FEATURE_ROWS  -> feature row[addr-FEATURE_BASE]
//      any other address -> data_out=0, data_valid=1, addr_err set (sticky until reset)
//  - enable_read low: data_out holds its last value; data_valid=0.
//  - enable_read outside SERVE is ignored: data_valid=0, no error, read_count unchanged.
//  - COO: in SERVE, coo_out is registered every cycle from coo_address (1-cycle latency).
//    coo_address >= COO_NUM_OF_COLS gives 0, with no error. Outside SERVE, coo_out=0.
//  - Reset deasserting mid-LOAD or mid-read restarts in IDLE. A full reload is required.
// CONFIGURATION
//  GCN_MEM_RDCNT_EN defined:
//    - read_count increments on every accepted read, out-of-range reads included.
//    - Saturates at 16'hFFFF. Clears on reset and on load_start.
//  GCN_MEM_RDCNT_EN undefined:
//    - read_count tied to 0 and no counter flops are built.
//    - All other behaviour is identical.
// TESTING
//  T1 Reset: reset=0 mid-LOAD at beat 100 -> all outputs 0, state IDLE.
//     After release, enable_read gives data_valid=0.
//  T2 Load then read:
//     - Stream 876 beats, weight[w][c]=(w+c)%32 and feature[r][c]=(r*3+c)%32 -> mem_ready=1
//       one cycle after beat 875.
//     - read_address=2 -> next cycle data_out elem0=2, elem95=1 ((2+95)%32), data_valid=1.
//  T3 Feature read:
//     - read_address=517 -> feature row 5: elem0=15, elem95=14 ((15+95)%32), addr_err=0.
//     - Back-to-back 512,513,514 -> three consecutive data_valid cycles, rows 0,1,2 in order.
//  T4 Out of range: read_address=3, then 518 -> data_out=0, data_valid=1, addr_err=1.
//     addr_err stays 1 through later valid reads.
//  T5 COO:
//     - Load COO rows {0,0,1,2,3,4} / {1,2,3,4,5,5}.
//     - coo_address=3 -> coo_out=6'b010_100; coo_address=7 -> coo_out=0.
//  T6 Reload/restart:
//     - load_start with load_valid at beat 50 -> that beat dropped, counter=0.
//     - load_start in SERVE -> mem_ready=0 next cycle.
//     - With GCN_MEM_RDCNT_EN, read_count resets to 0.

Source files
------------

// File: rtl/gcn_input_mem_server_if.sv
// Bus between the GCN loader/fetch side (master) and gcn_input_mem_server (slave).
// Carries the streaming load port, the row-read port and the COO column port.
interface gcn_input_mem_server_if #(
  parameter int FEATURE_COLS    = 96,
  parameter int ELEM_WIDTH      = 5,
  parameter int ADDRESS_WIDTH   = 13,
  parameter int COO_NUM_OF_ROWS = 2,
  parameter int COO_BW          = 3
);

  // Load handshake: a beat transfers on a rising edge where load_valid && load_ready.
  // load_ready is high for the whole LOAD state; the master may hold load_valid low to
  // stall, and load_data must be stable whenever load_valid is high.
  logic                                load_start;
  logic                                load_valid;
  logic [ELEM_WIDTH-1:0]               load_data;
  logic                                load_ready;
  logic                                mem_ready;

  logic                                enable_read;
  logic [ADDRESS_WIDTH-1:0]            read_address;
  logic [FEATURE_COLS*ELEM_WIDTH-1:0]  data_out;
  logic                                data_valid;

  logic [COO_BW-1:0]                   coo_address;
  logic [COO_NUM_OF_ROWS*COO_BW-1:0]   coo_out;

  logic                                addr_err;
  logic [15:0]                         read_count;

  modport master (
    output load_start, load_valid, load_data, enable_read, read_address, coo_address,
    input  load_ready, mem_ready, data_out, data_valid, coo_out, addr_err, read_count
  );

  modport slave (
    input  load_start, load_valid, load_data, enable_read, read_address, coo_address,
    output load_ready, mem_ready, data_out, data_valid, coo_out, addr_err, read_count
  );

endinterface

// File: rtl/gcn_input_mem_server.sv
// Weight/feature/COO store for the GCN fetch port, filled by a streaming loader.
// Optional read counter enabled with macro GCN_MEM_RDCNT_EN.
module gcn_input_mem_server #(
  parameter int FEATURE_ROWS    = 6,
  parameter int FEATURE_COLS    = 96,
  parameter int WEIGHT_COLS     = 3,
  parameter int ELEM_WIDTH      = 5,
  parameter int ADDRESS_WIDTH   = 13,
  parameter int FEATURE_BASE    = 512,
  parameter int COO_NUM_OF_COLS = 6,
  parameter int COO_NUM_OF_ROWS = 2,
  parameter int COO_BW          = 3,
  localparam int TOTAL_BEATS    = WEIGHT_COLS*FEATURE_COLS + FEATURE_ROWS*FEATURE_COLS
                                  + COO_NUM_OF_ROWS*COO_NUM_OF_COLS,
  localparam int BEAT_W         = $clog2(TOTAL_BEATS)
) (
  input  logic                     clk,
  input  logic                     reset,
  gcn_input_mem_server_if.slave    bus,
  output logic [1:0]               dbg_state_o,
  output logic [BEAT_W-1:0]        dbg_beat_cnt_o
);

  localparam int ROW_W = FEATURE_COLS * ELEM_WIDTH;
  localparam int LSB_W = $clog2(ROW_W);
  localparam int COL_W = $clog2(FEATURE_COLS);
  localparam int RW    = $clog2(FEATURE_ROWS);
  localparam int WRW   = $clog2(WEIGHT_COLS);
  localparam int CRW   = $clog2(COO_NUM_OF_ROWS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEG_W = 2'd0,
    SEG_F = 2'd1,
    SEG_C = 2'd2
  } seg_e;

  state_e              state_q, state_d;
  seg_e                seg_q, seg_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [RW-1:0]       row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic                accept;
  logic [COL_W-1:0]    last_col;
  logic [RW-1:0]       last_row;

  logic [ROW_W-1:0]    weight_mem  [WEIGHT_COLS];
  logic [ROW_W-1:0]    feature_mem [FEATURE_ROWS];
  logic [COO_BW-1:0]   coo_mem     [COO_NUM_OF_ROWS][COO_NUM_OF_COLS];
  logic [LSB_W-1:0]    elem_lsb;

  logic                         rd_accept;
  logic                         is_w, is_f;
  logic [ADDRESS_WIDTH-1:0]     f_off;
  logic [ROW_W-1:0]             rd_row;
  logic                         coo_hit;
  logic [COO_NUM_OF_ROWS*COO_BW-1:0] coo_row;

  logic [ROW_W-1:0]                  data_out_q;
  logic                              data_valid_q;
  logic                              addr_err_q;
  logic [COO_NUM_OF_ROWS*COO_BW-1:0] coo_out_q;

  // ---------------- load sequencer ----------------
  always_comb begin
    last_col = (seg_q == SEG_C) ? COL_W'(COO_NUM_OF_COLS-1) : COL_W'(FEATURE_COLS-1);
    case (seg_q)
      SEG_W:   last_row = RW'(WEIGHT_COLS-1);
      SEG_F:   last_row = RW'(FEATURE_ROWS-1);
      default: last_row = RW'(COO_NUM_OF_ROWS-1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    beat_d  = beat_q;
    row_d   = row_q;
    col_d   = col_q;
    accept  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.load_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // A restart in the same cycle as a beat wins; the beat is dropped.
        if (!bus.load_start && bus.load_valid) begin
          accept = 1'b1;
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(TOTAL_BEATS-1)) begin
            state_d = ST_SERVE;
            beat_d  = '0;
            seg_d   = SEG_W;
            row_d   = '0;
            col_d   = '0;
          end else if (col_q == last_col) begin
            col_d = '0;
            if (row_q == last_row) begin
              row_d = '0;
              seg_d = (seg_q == SEG_W) ? SEG_F : SEG_C;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      ST_SERVE: begin
        if (bus.load_start) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.load_start) begin
      beat_d = '0;
      seg_d  = SEG_W;
      row_d  = '0;
      col_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      seg_q   <= SEG_W;
      beat_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      beat_q  <= beat_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Element 0 lands in the row MSBs.
  assign elem_lsb = LSB_W'(COL_W'(FEATURE_COLS-1) - col_q) * LSB_W'(ELEM_WIDTH);

  always_ff @(posedge clk) begin
    if (accept) begin
      case (seg_q)
        SEG_W:   weight_mem[row_q[WRW-1:0]][elem_lsb +: ELEM_WIDTH] <= bus.load_data;
        SEG_F:   feature_mem[row_q][elem_lsb +: ELEM_WIDTH] <= bus.load_data;
        default: coo_mem[row_q[CRW-1:0]][col_q[COO_BW-1:0]] <= bus.load_data[COO_BW-1:0];
      endcase
    end
  end

  // ---------------- read paths ----------------
  assign rd_accept = (state_q == ST_SERVE) && bus.enable_read;
  assign is_w      = bus.read_address < ADDRESS_WIDTH'(WEIGHT_COLS);
  assign f_off     = bus.read_address - ADDRESS_WIDTH'(FEATURE_BASE);
  assign is_f      = (bus.read_address >= ADDRESS_WIDTH'(FEATURE_BASE)) &&
                     (f_off < ADDRESS_WIDTH'(FEATURE_ROWS));

  always_comb begin
    rd_row = '0;
    if (is_w)      rd_row = weight_mem[bus.read_address[WRW-1:0]];
    else if (is_f) rd_row = feature_mem[f_off[RW-1:0]];
  end

  assign coo_hit = bus.coo_address < COO_BW'(COO_NUM_OF_COLS);

  always_comb begin
    coo_row = '0;
    if (coo_hit) begin
      for (int r = 0; r < COO_NUM_OF_ROWS; r++) begin
        coo_row[(COO_NUM_OF_ROWS-1-r)*COO_BW +: COO_BW] = coo_mem[CRW'(r)][bus.coo_address];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      coo_out_q    <= '0;
    end else begin
      data_valid_q <= rd_accept;
      if (rd_accept) begin
        data_out_q <= rd_row;
        if (!(is_w || is_f)) addr_err_q <= 1'b1;
      end
      coo_out_q <= (state_q == ST_SERVE) ? coo_row : '0;
    end
  end

`ifdef GCN_MEM_RDCNT_EN
  logic [15:0] rd_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt_q <= '0;
    end else if (bus.load_start) begin
      rd_cnt_q <= '0;
    end else if (rd_accept && (rd_cnt_q != 16'hFFFF)) begin
      rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  assign bus.read_count = rd_cnt_q;
`else
  assign bus.read_count = '0;
`endif

  assign bus.load_ready  = (state_q == ST_LOAD);
  assign bus.mem_ready   = (state_q == ST_SERVE);
  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.addr_err    = addr_err_q;
  assign bus.coo_out     = coo_out_q;

  assign dbg_state_o     = state_q;
  assign dbg_beat_cnt_o  = beat_q;

endmodule

// File: tb/tb_gcn_input_mem_server.sv
// Directed bench for gcn_input_mem_server: reset, load, row/COO reads, range errors, reload.
module tb_gcn_input_mem_server;

  localparam int ROW_W = 480;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  logic [9:0] dbg_beat;

  gcn_input_mem_server_if bus ();

  gcn_input_mem_server dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .dbg_state_o    (dbg_state),
    .dbg_beat_cnt_o (dbg_beat)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int exp_rd   = 0;
  logic [ROW_W-1:0] exp_q[$];

  int coo_r0[6] = '{0, 0, 1, 2, 3, 4};
  int coo_r1[6] = '{1, 2, 3, 4, 5, 5};

  task automatic check(input string tag, input logic [ROW_W-1:0] got,
                       input logic [ROW_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] w_row(input int w);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int c = 0; c < 96; c++) r[(95-c)*5 +: 5] = 5'((w + c) % 32);
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] f_row(input int f);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int c = 0; c < 96; c++) r[(95-c)*5 +: 5] = 5'((f*3 + c) % 32);
    return r;
  endfunction

  function automatic logic [4:0] beat_data(input int i);
    int j;
    if (i < 288) return 5'(((i / 96) + (i % 96)) % 32);
    if (i < 864) begin
      j = i - 288;
      return 5'(((j / 96) * 3 + (j % 96)) % 32);
    end
    j = i - 864;
    if (j < 6) return 5'(coo_r0[j]);
    return 5'(coo_r1[j-6]);
  endfunction

  function automatic logic [15:0] rd_exp();
`ifdef GCN_MEM_RDCNT_EN
    return 16'(exp_rd);
`else
    return 16'd0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load_start();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic stream(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = beat_data(i);
      tick();
    end
    bus.load_valid = 1'b0;
  endtask

  task automatic issue_read(input string tag, input int addr, input logic [ROW_W-1:0] exp);
    bus.enable_read  = 1'b1;
    bus.read_address = 13'(addr);
    exp_q.push_back(exp);
    exp_rd++;
    tick();
    check({tag, "_valid"}, bus.data_valid, 1'b1);
    check({tag, "_data"}, bus.data_out, exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset            = 1'b0;
    bus.load_start   = 1'b0;
    bus.load_valid   = 1'b0;
    bus.load_data    = '0;
    bus.enable_read  = 1'b0;
    bus.read_address = '0;
    bus.coo_address  = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    check("rst_load_ready", bus.load_ready, 1'b0);
    check("rst_mem_ready",  bus.mem_ready,  1'b0);
    check("rst_data_out",   bus.data_out,   '0);
    check("rst_data_valid", bus.data_valid, 1'b0);
    check("rst_coo_out",    bus.coo_out,    '0);
    check("rst_addr_err",   bus.addr_err,   1'b0);
    check("rst_read_count", bus.read_count, 16'd0);
    check("rst_state",      dbg_state,      2'd0);

    // T1: reset in the middle of a load
    pulse_load_start();
    check("t1_load_ready", bus.load_ready, 1'b1);
    stream(0, 99);
    check("t1_beat100", dbg_beat, 10'd100);
    #2 reset = 1'b0;
    #1;
    check("t1_async_state",      dbg_state,      2'd0);
    check("t1_async_beat",       dbg_beat,       10'd0);
    check("t1_async_load_ready", bus.load_ready, 1'b0);
    check("t1_async_mem_ready",  bus.mem_ready,  1'b0);
    tick();
    reset = 1'b1;
    exp_rd = 0;
    bus.enable_read  = 1'b1;
    bus.read_address = 13'd0;
    tick();
    bus.enable_read = 1'b0;
    check("t1_idle_read_valid", bus.data_valid, 1'b0);
    check("t1_idle_read_err",   bus.addr_err,   1'b0);
    check("t1_idle_read_cnt",   bus.read_count, 16'd0);

    // T6a + T2: restart mid-load with a colliding beat, then a full load
    pulse_load_start();
    stream(0, 49);
    check("t6_beat50", dbg_beat, 10'd50);
    bus.load_start = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 5'd31;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    check("t6_restart_beat",  dbg_beat,  10'd0);
    check("t6_restart_state", dbg_state, 2'd1);
    stream(0, 874);
    check("t2_mem_ready_early", bus.mem_ready, 1'b0);
    stream(875, 875);
    check("t2_mem_ready",  bus.mem_ready,  1'b1);
    check("t2_load_ready", bus.load_ready, 1'b0);
    check("t2_state",      dbg_state,      2'd2);

    issue_read("t2_w2", 2, w_row(2));
    bus.enable_read = 1'b0;
    check("t2_w2_elem0",  bus.data_out[479:475], 5'd2);
    check("t2_w2_elem95", bus.data_out[4:0],     5'd1);
    tick();
    check("t2_idle_valid", bus.data_valid, 1'b0);
    check("t2_idle_hold",  bus.data_out,   w_row(2));

    // T3: feature rows
    issue_read("t3_f5", 517, f_row(5));
    bus.enable_read = 1'b0;
    check("t3_f5_elem0",  bus.data_out[479:475], 5'd15);
    check("t3_f5_elem95", bus.data_out[4:0],     5'd14);
    check("t3_f5_err",    bus.addr_err,          1'b0);
    for (int k = 0; k < 3; k++) issue_read("t3_b2b", 512 + k, f_row(k));
    bus.enable_read = 1'b0;

    // T4: out-of-range addresses
    issue_read("t4_a3", 3, '0);
    check("t4_a3_err", bus.addr_err, 1'b1);
    issue_read("t4_a518", 518, '0);
    issue_read("t4_w0", 0, w_row(0));
    bus.enable_read = 1'b0;
    check("t4_err_sticky", bus.addr_err,   1'b1);
    check("t4_read_count", bus.read_count, rd_exp());

    // T5: COO columns
    bus.coo_address = 3'd3;
    tick();
    check("t5_coo3", bus.coo_out, 6'b010_100);
    bus.coo_address = 3'd7;
    tick();
    check("t5_coo7", bus.coo_out, 6'd0);
    bus.coo_address = 3'd0;
    tick();
    check("t5_coo0", bus.coo_out, 6'b000_001);

    // T6b: reload from SERVE
    pulse_load_start();
    exp_rd = 0;
    check("t6_mem_ready",  bus.mem_ready,  1'b0);
    check("t6_state",      dbg_state,      2'd1);
    check("t6_read_count", bus.read_count, rd_exp());
    check("t6_data_hold",  bus.data_out,   w_row(0));
    bus.enable_read  = 1'b1;
    bus.read_address = 13'd1;
    tick();
    bus.enable_read = 1'b0;
    check("t6_load_read_valid", bus.data_valid, 1'b0);
    check("t6_load_coo",        bus.coo_out,    6'd0);
    check("t6_load_read_cnt",   bus.read_count, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
